// File: rtl/cmd_pkg.sv
// cmd_pkg: shared FSM/owner encodings and field width for the command-path arbiter
package cmd_pkg;
  localparam int FW = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3} state_t;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
endpackage

// File: rtl/cmd_rr_pick.sv
// cmd_rr_pick: combinational two-way round-robin picker, a tie goes to the side that did not win last
module cmd_rr_pick
  import cmd_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_t last_grant,
  output logic   grant_vld,
  output owner_t grant_id
);
  always_comb begin
    grant_vld = req_a | req_b;
    grant_id  = owner_t'(req_b & (~req_a | (last_grant == OWN_A)));
  end
endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin sequencer granting the shared command path to requester A or B and returning cmd_q after RESP_LAT cycles
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int RESP_LAT = 2,
  parameter int CW       = 4
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [FW-1:0] a_dev,
  input  logic [FW-1:0] a_mod,
  input  logic [FW-1:0] a_addr,
  input  logic [FW-1:0] a_data,
  input  logic          a_req,
  output logic          a_ack,
  output logic [FW-1:0] a_q,
  input  logic [FW-1:0] b_dev,
  input  logic [FW-1:0] b_mod,
  input  logic [FW-1:0] b_addr,
  input  logic [FW-1:0] b_data,
  input  logic          b_req,
  output logic          b_ack,
  output logic [FW-1:0] b_q,
  output logic [FW-1:0] cmd_dev,
  output logic [FW-1:0] cmd_mod,
  output logic [FW-1:0] cmd_addr,
  output logic [FW-1:0] cmd_data,
  output logic          cmd_vld,
  input  logic [FW-1:0] cmd_q,
  output logic          busy
);
  state_t        state;
  owner_t        owner;
  owner_t        last_grant;
  owner_t        grant_id;
  logic          grant_vld;
  logic [CW-1:0] cnt;
  logic          pick_b;
  cmd_rr_pick u_pick (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );
  always_comb pick_b = grant_id == OWN_B;
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_A;
      last_grant <= OWN_B;
      cnt        <= '0;
      cmd_dev    <= '0;
      cmd_mod    <= '0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      cmd_vld    <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (grant_vld) begin
            owner    <= grant_id;
            cmd_dev  <= pick_b ? b_dev  : a_dev;
            cmd_mod  <= pick_b ? b_mod  : a_mod;
            cmd_addr <= pick_b ? b_addr : a_addr;
            cmd_data <= pick_b ? b_data : a_data;
            cmd_vld  <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        ST_ISSUE: begin
          cmd_vld <= 1'b0;
          cnt     <= CW'(RESP_LAT - 1);
          state   <= ST_WAIT;
        end
        ST_WAIT:
          if (cnt == '0) begin
            if (owner == OWN_A) a_q <= cmd_q;
            else b_q <= cmd_q;
            a_ack <= owner == OWN_A;
            b_ack <= owner == OWN_B;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        ST_DONE: begin
          a_ack      <= 1'b0;
          b_ack      <= 1'b0;
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: directed self-checking bench for cmd_arbiter at RESP_LAT=2 and RESP_LAT=1
module tb_cmd_arbiter;
  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic [7:0] a_dev, a_mod, a_addr, a_data, b_dev, b_mod, b_addr, b_data;
  logic       a_req, b_req;
  logic [7:0] cmd_q, cmd_q1;
  logic       a_ack, b_ack, cmd_vld, busy;
  logic [7:0] a_q, b_q, cmd_dev, cmd_mod, cmd_addr, cmd_data;
  logic       a_ack1, b_ack1, cmd_vld1, busy1;
  logic [7:0] a_q1, b_q1, cmd_dev1, cmd_mod1, cmd_addr1, cmd_data1;
  logic [51:0] outs;
  int n_cmp = 0;
  int n_err = 0;
  int n_ack, n_vld;
  always #5 clk_sys = ~clk_sys;
  assign outs = {cmd_dev, cmd_mod, cmd_addr, cmd_data, cmd_vld, a_ack, b_ack, a_q, b_q, busy};
  cmd_arbiter #(.RESP_LAT(2), .CW(4)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .a_dev(a_dev), .a_mod(a_mod), .a_addr(a_addr), .a_data(a_data), .a_req(a_req), .a_ack(a_ack), .a_q(a_q),
    .b_dev(b_dev), .b_mod(b_mod), .b_addr(b_addr), .b_data(b_data), .b_req(b_req), .b_ack(b_ack), .b_q(b_q),
    .cmd_dev(cmd_dev), .cmd_mod(cmd_mod), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_vld(cmd_vld),
    .cmd_q(cmd_q), .busy(busy)
  );
  cmd_arbiter #(.RESP_LAT(1), .CW(4)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .a_dev(a_dev), .a_mod(a_mod), .a_addr(a_addr), .a_data(a_data), .a_req(a_req), .a_ack(a_ack1), .a_q(a_q1),
    .b_dev(b_dev), .b_mod(b_mod), .b_addr(b_addr), .b_data(b_data), .b_req(b_req), .b_ack(b_ack1), .b_q(b_q1),
    .cmd_dev(cmd_dev1), .cmd_mod(cmd_mod1), .cmd_addr(cmd_addr1), .cmd_data(cmd_data1), .cmd_vld(cmd_vld1),
    .cmd_q(cmd_q1), .busy(busy1)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {a_dev, a_mod, a_addr, a_data, b_dev, b_mod, b_addr, b_data} = '0;
    {a_req, b_req} = 2'b00;
    cmd_q  = 8'h00;
    cmd_q1 = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    do_reset();
    rst_n = 1'b0;
    tick();
    check("reset_outs", outs, 52'h0);
    check("reset_outs1", {cmd_vld1, a_ack1, b_ack1, a_q1, b_q1, busy1}, 20'h0);
    rst_n = 1'b1;
    tick();
    {a_dev, a_mod, a_addr, a_data} = 32'h01020304;
    a_req = 1'b1;
    cmd_q = 8'hEE;
    check("t1_vld_c0", cmd_vld, 1'b0);
    tick();
    check("t1_vld_c1", cmd_vld, 1'b1);
    check("t1_fields", {cmd_dev, cmd_mod, cmd_addr, cmd_data}, 32'h01020304);
    check("t1_busy_c1", busy, 1'b1);
    tick();
    check("t1_vld_c2", cmd_vld, 1'b0);
    check("t1_ack_c2", a_ack, 1'b0);
    tick();
    cmd_q = 8'h5A;
    check("t1_ack_c3", a_ack, 1'b0);
    tick();
    cmd_q = 8'h11;
    check("t1_a_ack", a_ack, 1'b1);
    check("t1_a_q", a_q, 8'h5A);
    check("t1_b_ack", b_ack, 1'b0);
    check("t1_b_q", b_q, 8'h00);
    a_req = 1'b0;
    tick();
    check("t1_ack_drop", a_ack, 1'b0);
    check("t1_busy_c5", busy, 1'b0);
    check("t1_a_q_hold", a_q, 8'h5A);
    n_vld = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vld += int'(cmd_vld);
    end
    check("t1_no_revld", n_vld, 0);
    do_reset();
    a_data = 8'hAA;
    b_data = 8'hBB;
    a_req = 1'b1;
    b_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("alt_vld", cmd_vld, (i % 5) == 1);
      if ((i % 5) == 1) check("alt_data", cmd_data, ((i / 5) % 2 == 0) ? 8'hAA : 8'hBB);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    do_reset();
    {b_dev, b_mod, b_addr, b_data} = 32'h0A0B0C0D;
    b_req = 1'b1;
    cmd_q1 = 8'h99;
    tick();
    check("l1_vld", cmd_vld1, 1'b1);
    check("l1_fields", {cmd_dev1, cmd_mod1, cmd_addr1, cmd_data1}, 32'h0A0B0C0D);
    tick();
    cmd_q1 = 8'hC3;
    check("l1_ack_early", b_ack1, 1'b0);
    tick();
    cmd_q1 = 8'h00;
    b_req = 1'b0;
    check("l1_b_ack", b_ack1, 1'b1);
    check("l1_b_q", b_q1, 8'hC3);
    check("l1_a_q", {a_ack1, a_q1}, 9'h0);
    do_reset();
    {a_dev, a_mod, a_addr, a_data} = 32'h41424344;
    a_req = 1'b1;
    tick();
    check("t4_vld", cmd_vld, 1'b1);
    tick();
    a_data = 8'hFF;
    tick();
    cmd_q = 8'h77;
    check("t4_data_wait", cmd_data, 8'h44);
    tick();
    a_req = 1'b0;
    check("t4_ack", a_ack, 1'b1);
    check("t4_a_q", a_q, 8'h77);
    check("t4_data_done", cmd_data, 8'h44);
    tick();
    a_data = 8'h44;
    a_req = 1'b1;
    tick();
    check("t5_vld", cmd_vld, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_req = 1'b0;
    check("t5_rst_outs", outs, 52'h0);
    n_ack = 0;
    n_vld = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_ack += int'(a_ack) + int'(b_ack);
      n_vld += int'(cmd_vld);
    end
    check("t5_no_ack", n_ack, 0);
    check("t5_no_vld", n_vld, 0);
    {b_dev, b_mod, b_addr, b_data} = 32'h21222324;
    b_req = 1'b1;
    tick();
    check("t5_b_vld", cmd_vld, 1'b1);
    check("t5_b_fields", {cmd_dev, cmd_mod, cmd_addr, cmd_data}, 32'h21222324);
    tick();
    tick();
    cmd_q = 8'h6B;
    tick();
    b_req = 1'b0;
    check("t5_b_ack", b_ack, 1'b1);
    check("t5_b_q", b_q, 8'h6B);
    do_reset();
    {a_dev, a_mod, a_addr, a_data} = 32'h51525354;
    a_req = 1'b1;
    cmd_q = 8'h3C;
    tick();
    check("t6_vld", cmd_vld, 1'b1);
    tick();
    a_req = 1'b0;
    {a_dev, a_mod, a_addr, a_data} = 32'hF1F2F3F4;
    n_ack = 0;
    n_vld = 0;
    for (int i = 0; i < 10; i++) begin
      n_ack += int'(a_ack) + int'(b_ack);
      n_vld += int'(cmd_vld);
      tick();
    end
    check("t6_one_ack", n_ack, 1);
    check("t6_no_vld", n_vld, 0);
    check("t6_a_q", a_q, 8'h3C);
    check("t6_fields_hold", {cmd_dev, cmd_mod, cmd_addr, cmd_data}, 32'h51525354);
    check("t6_idle", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
